// File: rtl/chip8_decode_pipe.sv
// rtl/chip8_decode_pipe.sv - CHIP-8 opcode decoder feeding a DEPTH-entry output FIFO.
// Optional SUPER-CHIP decoding is enabled by defining CHIP8_SCHIP_EN.
module chip8_decode_pipe #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 2,
   parameter int OP_W   = 6,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instruction,
   input  logic [ADDR_W-1:0] instr_pc,
   input  logic              flush,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [OP_W-1:0]   op_code,
   output logic [3:0]        op_x,
   output logic [3:0]        op_y,
   output logic [3:0]        op_nib,
   output logic [7:0]        op_val,
   output logic [ADDR_W-1:0] op_addr,
   output logic [ADDR_W-1:0] op_pc,
   output logic              op_illegal,
   output logic [CNT_W-1:0]  illegal_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_FW = $clog2(DEPTH + 1);

   // Only the low 12 bits are kept: every operand field is a slice of them.
   typedef struct packed {
      logic [OP_W-1:0]   code;
      logic              ill;
      logic [11:0]       ins;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_FW-1:0] count;
   logic [5:0]        d_code;
   logic              d_ill;
   logic              accept;
   logic              pop;
   entry_t            head;

   always_comb begin
      d_code = 6'd0;
      case (instruction[15:12])
         4'h0: begin
            if (instruction == 16'h00E0)      d_code = 6'd1;
            else if (instruction == 16'h00EE) d_code = 6'd2;
`ifdef CHIP8_SCHIP_EN
            else if (instruction[15:4] == 12'h00C) d_code = 6'd35;
            else if (instruction == 16'h00FB) d_code = 6'd36;
            else if (instruction == 16'h00FC) d_code = 6'd37;
            else if (instruction == 16'h00FD) d_code = 6'd38;
            else if (instruction == 16'h00FE) d_code = 6'd39;
            else if (instruction == 16'h00FF) d_code = 6'd40;
`endif
         end
         4'h1: d_code = 6'd3;
         4'h2: d_code = 6'd4;
         4'h3: d_code = 6'd5;
         4'h4: d_code = 6'd6;
         4'h5: if (instruction[3:0] == 4'h0) d_code = 6'd7;
         4'h6: d_code = 6'd8;
         4'h7: d_code = 6'd9;
         4'h8: begin
            if (instruction[3] == 1'b0)        d_code = 6'd10 + {3'd0, instruction[2:0]};
            else if (instruction[3:0] == 4'hE) d_code = 6'd18;
         end
         4'h9: if (instruction[3:0] == 4'h0) d_code = 6'd19;
         4'hA: d_code = 6'd20;
         4'hB: d_code = 6'd21;
         4'hC: d_code = 6'd22;
         // Dxy0 is the 16x16 SUPER-CHIP sprite; the decode is identical either way.
         4'hD: d_code = 6'd23;
         4'hE: begin
            if (instruction[7:0] == 8'h9E)      d_code = 6'd24;
            else if (instruction[7:0] == 8'hA1) d_code = 6'd25;
         end
         4'hF: begin
            case (instruction[7:0])
               8'h07:   d_code = 6'd26;
               8'h0A:   d_code = 6'd27;
               8'h15:   d_code = 6'd28;
               8'h18:   d_code = 6'd29;
               8'h1E:   d_code = 6'd30;
               8'h29:   d_code = 6'd31;
               8'h33:   d_code = 6'd32;
               8'h55:   d_code = 6'd33;
               8'h65:   d_code = 6'd34;
`ifdef CHIP8_SCHIP_EN
               8'h30:   d_code = 6'd41;
               8'h75:   d_code = 6'd42;
               8'h85:   d_code = 6'd43;
`endif
               default: d_code = 6'd0;
            endcase
         end
         default: d_code = 6'd0;
      endcase
      d_ill = (d_code == 6'd0);
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   assign instr_ready = !rst && !flush && (count < CNT_FW'(DEPTH));
   assign accept      = instr_valid && instr_ready;
   assign op_valid    = (count != '0);
   assign pop         = op_valid && op_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         illegal_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // accept is already blocked during flush, so the counter needs no flush term.
         if (accept && d_ill && (illegal_cnt != {CNT_W{1'b1}}))
            illegal_cnt <= illegal_cnt + 1'b1;
         if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (accept) begin
               mem[wr_ptr] <= '{code: OP_W'(d_code), ill: d_ill,
                                ins: instruction[11:0], pc: instr_pc};
               wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (accept && !pop)      count <= count + 1'b1;
            else if (!accept && pop) count <= count - 1'b1;
         end
      end
   end

   assign head       = mem[rd_ptr];
   assign op_code    = head.code;
   assign op_illegal = head.ill;
   assign op_x       = head.ins[11:8];
   assign op_y       = head.ins[7:4];
   assign op_nib     = head.ins[3:0];
   assign op_val     = head.ins[7:0];
   assign op_addr    = ADDR_W'(head.ins);
   assign op_pc      = head.pc;

endmodule

// File: tb/tb_chip8_decode_pipe.sv
// tb/tb_chip8_decode_pipe.sv - scoreboard bench for chip8_decode_pipe (honours CHIP8_SCHIP_EN).
module tb_chip8_decode_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instruction = '0;
   logic [11:0] instr_pc = '0;
   logic        flush = 1'b0;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [5:0]  op_code;
   logic [3:0]  op_x, op_y, op_nib;
   logic [7:0]  op_val;
   logic [11:0] op_addr, op_pc;
   logic        op_illegal;
   logic [7:0]  illegal_cnt;

   typedef struct {
      logic [5:0]  code;
      logic        ill;
      logic [15:0] ins;
      logic [11:0] pc;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   exp_cnt = 0;

   chip8_decode_pipe #(.ADDR_W(12), .DEPTH(2), .OP_W(6), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .instr_pc(instr_pc), .flush(flush),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_x(op_x),
      .op_y(op_y), .op_nib(op_nib), .op_val(op_val), .op_addr(op_addr),
      .op_pc(op_pc), .op_illegal(op_illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && op_valid && op_ready) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_head actual=%h required=none", op_code);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("head", {op_code, op_illegal, op_x, op_y, op_nib, op_val, op_addr, op_pc},
                  {e.code, e.ill, e.ins[11:8], e.ins[7:4], e.ins[3:0], e.ins[7:0],
                   e.ins[11:0], e.pc});
         end
      end
   end

   task automatic push(input logic [15:0] ins, input logic [11:0] pc, input logic [5:0] code);
      int   n = 0;
      exp_t e;
      while (!instr_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!instr_ready) begin
         total++;
         bad++;
         $display("FAIL push_timeout actual=ready_low required=ready_high");
         return;
      end
      instruction = ins;
      instr_pc    = pc;
      instr_valid = 1'b1;
      @(posedge clk);
      e.code = code; e.ill = (code == 6'd0); e.ins = ins; e.pc = pc;
      sbq.push_back(e);
      if (code == 6'd0 && exp_cnt < 255) exp_cnt++;
      #1 instr_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
      end
   endtask

   logic [15:0] vec_ins  [12] = '{16'h5121, 16'h8AB8, 16'h0123, 16'h8AB4, 16'h8ABE, 16'h9AB0,
                                  16'hE19E, 16'hEAA1, 16'hF265, 16'hF033, 16'hD125, 16'hB123};
   logic [5:0]  vec_code [12] = '{6'd0, 6'd0, 6'd0, 6'd14, 6'd18, 6'd19,
                                  6'd24, 6'd25, 6'd34, 6'd32, 6'd23, 6'd21};

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", op_valid, 0);
      check("rst_ready", instr_ready, 0);
      check("rst_cnt", illegal_cnt, 0);
      check("rst_fields", {op_code, op_illegal, op_x, op_y, op_nib, op_val, op_addr, op_pc}, 0);
      rst = 1'b0;

      op_ready = 1'b1;
      push(16'h6A3F, 12'h200, 6'd8);
      check("latency_valid", op_valid, 1);
      wait_empty();

      op_ready = 1'b0;
      push(16'h00E0, 12'h202, 6'd1);
      push(16'h2345, 12'h204, 6'd4);
      check("ready_full", instr_ready, 0);
      op_ready = 1'b1;
      wait_empty();

      for (int i = 0; i < 3; i++) push(vec_ins[i], 12'h300 + 12'(i), vec_code[i]);
      wait_empty();
      check("cnt_three", illegal_cnt, 3);
      for (int i = 3; i < 12; i++) push(vec_ins[i], 12'h300 + 12'(i), vec_code[i]);
      wait_empty();

      op_ready = 1'b0;
      push(16'h6000, 12'h400, 6'd8);
      push(16'h7001, 12'h402, 6'd9);
      check("flush_full", instr_ready, 0);
      flush = 1'b1; instr_valid = 1'b1; instruction = 16'h0123;
      @(posedge clk); #1;
      sbq.delete();
      check("flush_valid", op_valid, 0);
      for (int i = 0; i < 2; i++) begin
         check("flush_hold_ready", instr_ready, 0);
         @(posedge clk); #1;
      end
      flush = 1'b0; instr_valid = 1'b0;
      check("flush_empty_valid", op_valid, 0);
      check("flush_cnt", illegal_cnt, 8'(exp_cnt));

      op_ready = 1'b1;
      push(16'h6A3F, 12'h410, 6'd8);
      wait_empty();

`ifdef CHIP8_SCHIP_EN
      push(16'h00FF, 12'h500, 6'd40);
      push(16'hF375, 12'h502, 6'd42);
`else
      push(16'h00FF, 12'h500, 6'd0);
      push(16'hF375, 12'h502, 6'd0);
`endif
      wait_empty();
      check("schip_cnt", illegal_cnt, 8'(exp_cnt));

      op_ready = 1'b0;
      push(16'h1234, 12'h600, 6'd3);
      push(16'h2456, 12'h602, 6'd4);
      check("prerst_valid", op_valid, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      sbq.delete();
      exp_cnt = 0;
      check("arst_valid", op_valid, 0);
      check("arst_ready", instr_ready, 0);
      check("arst_cnt", illegal_cnt, 0);
      check("arst_fields", {op_code, op_illegal, op_x, op_y, op_nib, op_val, op_addr, op_pc}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      op_ready = 1'b1;
      for (int i = 0; i < 256; i++) push(16'h0123, 12'(i), 6'd0);
      wait_empty();
      check("sat_cnt", illegal_cnt, 255);
      push(16'h8ABF, 12'h700, 6'd0);
      wait_empty();
      check("sat_hold", illegal_cnt, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
